// File: rtl/trig_lut_pipe_if.sv
// rtl/trig_lut_pipe_if.sv - request/result handshake bundle for trig_lut_pipe
interface trig_lut_pipe_if #(
  parameter int DATA_W = 9
);
  logic                     in_valid;
  logic                     in_ready;
  logic [8:0]               angle;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] sin_out;
  logic signed [DATA_W-1:0] cos_out;
  logic                     wrapped;

  modport master (
    output in_valid, angle, out_ready,
    input  in_ready, out_valid, sin_out, cos_out, wrapped
  );

  modport slave (
    input  in_valid, angle, out_ready,
    output in_ready, out_valid, sin_out, cos_out, wrapped
  );
endinterface

// File: rtl/trig_lut_pipe.sv
// rtl/trig_lut_pipe.sv - 3-stage quarter-wave LUT sine/cosine pipeline
// Stage 1 folds the angle, stage 2 reads the table, stage 3 applies signs.
module trig_lut_pipe #(
  parameter int DATA_W = 9,
  parameter int AMP    = 2**(DATA_W-1)-1
) (
  input  logic           clk,
  input  logic           rst_n,
  trig_lut_pipe_if.slave bus
);

  // Series expansion keeps the table a pure elaboration-time constant.
  function automatic int lut_entry(input int k);
    real x;
    real term;
    real s;
    if (k == 0)  return 0;
    if (k == 90) return AMP;
    x    = real'(k) * 3.14159265358979323846 / 180.0;
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return $rtoi(real'(AMP) * s);
  endfunction

  logic [DATA_W-1:0] lut [0:90];

  for (genvar k = 0; k <= 90; k++) begin : g_lut
    localparam logic [DATA_W-1:0] ENTRY = DATA_W'(lut_entry(k));
    assign lut[k] = ENTRY;
  end

  logic              s1_valid_q, s2_valid_q, out_valid_q;
  logic [1:0]        s1_quad_q, s2_quad_q;
  logic              s1_wrap_q, s2_wrap_q, wrap_q;
  logic [6:0]        s1_sin_idx_q, s1_cos_idx_q;
  logic [DATA_W-1:0] s2_sin_q, s2_cos_q;
  logic [DATA_W-1:0] sin_q, cos_q;

  logic              adv;
  logic              wrap_d;
  logic [8:0]        red_d;
  logic [1:0]        quad_d;
  logic [6:0]        sin_idx_d, cos_idx_d;
  logic [DATA_W-1:0] sin_d, cos_d;

  assign adv           = bus.out_ready || !out_valid_q;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;
  assign bus.wrapped   = wrap_q;

  always_comb begin
    wrap_d = (bus.angle >= 9'd360);
    red_d  = wrap_d ? bus.angle - 9'd360 : bus.angle;
    if (red_d < 9'd90) begin
      quad_d    = 2'd0;
      sin_idx_d = 7'(red_d);
      cos_idx_d = 7'(9'd90 - red_d);
    end else if (red_d < 9'd180) begin
      quad_d    = 2'd1;
      sin_idx_d = 7'(9'd180 - red_d);
      cos_idx_d = 7'(red_d - 9'd90);
    end else if (red_d < 9'd270) begin
      quad_d    = 2'd2;
      sin_idx_d = 7'(red_d - 9'd180);
      cos_idx_d = 7'(9'd270 - red_d);
    end else begin
      quad_d    = 2'd3;
      sin_idx_d = 7'(9'd360 - red_d);
      cos_idx_d = 7'(red_d - 9'd270);
    end
  end

  // Sine is negative in q2/q3, cosine in q1/q2; negating zero stays zero.
  always_comb begin
    sin_d = s2_quad_q[1] ? -s2_sin_q : s2_sin_q;
    cos_d = (^s2_quad_q) ? -s2_cos_q : s2_cos_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_quad_q    <= '0;
      s1_wrap_q    <= 1'b0;
      s1_sin_idx_q <= '0;
      s1_cos_idx_q <= '0;
      s2_valid_q   <= 1'b0;
      s2_quad_q    <= '0;
      s2_wrap_q    <= 1'b0;
      s2_sin_q     <= '0;
      s2_cos_q     <= '0;
      out_valid_q  <= 1'b0;
      sin_q        <= '0;
      cos_q        <= '0;
      wrap_q       <= 1'b0;
    end else if (adv) begin
      s1_valid_q   <= bus.in_valid;
      s1_quad_q    <= quad_d;
      s1_wrap_q    <= wrap_d;
      s1_sin_idx_q <= sin_idx_d;
      s1_cos_idx_q <= cos_idx_d;
      s2_valid_q   <= s1_valid_q;
      s2_quad_q    <= s1_quad_q;
      s2_wrap_q    <= s1_wrap_q;
      s2_sin_q     <= lut[s1_sin_idx_q];
      s2_cos_q     <= lut[s1_cos_idx_q];
      out_valid_q  <= s2_valid_q;
      sin_q        <= sin_d;
      cos_q        <= cos_d;
      wrap_q       <= s2_wrap_q;
    end
  end

endmodule

// File: tb/tb_trig_lut_pipe.sv
// tb/tb_trig_lut_pipe.sv - scoreboard bench for trig_lut_pipe (DATA_W=9, AMP=255)
module tb_trig_lut_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  trig_lut_pipe_if #(.DATA_W(9)) bus ();

  trig_lut_pipe #(.DATA_W(9), .AMP(255)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_errors   = 0;
  int          stall_left = 0;
  int          got_cnt    = 0;
  bit          rand_mode  = 1'b0;
  bit          last_acc   = 1'b0;
  bit          held_valid = 1'b0;
  logic [18:0] held;
  logic [18:0] cur_exp;
  logic [18:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tval(input int k);
    real pi;
    pi = 3.14159265358979323846;
    if (k == 0)  return 0;
    if (k == 90) return 255;
    return int'($floor(255.0 * $sin(real'(k) * pi / 180.0)));
  endfunction

  function automatic logic [18:0] model(input int ang);
    int a, q, si, ci, sv, cv;
    bit w;
    w = (ang >= 360);
    a = w ? ang - 360 : ang;
    q = a / 90;
    case (q)
      0:       begin si = a;       ci = 90 - a;  end
      1:       begin si = 180 - a; ci = a - 90;  end
      2:       begin si = a - 180; ci = 270 - a; end
      default: begin si = 360 - a; ci = a - 270; end
    endcase
    sv = tval(si);
    cv = tval(ci);
    if (q >= 2) sv = -sv;
    if (q == 1 || q == 2) cv = -cv;
    return {w, 9'(sv), 9'(cv)};
  endfunction

  // One cycle: drive out_ready, sample just after the falling edge, then wait a cycle.
  task automatic step();
    logic [18:0] got;
    logic [18:0] e;
    bus.out_ready = (stall_left > 0) ? 1'b0 : (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (stall_left > 0) stall_left--;
    #1;
    got = {bus.wrapped, bus.sin_out, bus.cos_out};
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("result", 32'(got), 32'(e));
        got_cnt++;
      end
    end
    if (bus.out_valid && !bus.out_ready) begin
      check_val("in_ready_stall", 32'(bus.in_ready), 32'd0);
      if (held_valid) check_val("stall_hold", 32'(got), 32'(held));
      held       = got;
      held_valid = 1'b1;
    end else begin
      held_valid = 1'b0;
    end
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) exp_q.push_back(cur_exp);
    @(negedge clk);
  endtask

  task automatic send(input int ang, input logic [18:0] e);
    int tries;
    tries         = 0;
    bus.in_valid  = 1'b1;
    bus.angle     = 9'(ang);
    cur_exp       = e;
    last_acc      = 1'b0;
    while (!last_acc && tries < 100) begin
      step();
      tries++;
    end
    if (!last_acc) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    int t;
    t            = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && t < 300) begin
      step();
      t++;
    end
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     lat;
    int     cnt0;
    longint t0;
    int     stall_angles [4];
    stall_angles = '{45, 135, 225, 315};

    bus.in_valid  = 1'b0;
    bus.angle     = '0;
    bus.out_ready = 1'b1;

    // Reset asserted between clock edges must clear outputs immediately.
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_sin", 32'(bus.sin_out), 32'd0);
    check_val("rst_cos", 32'(bus.cos_out), 32'd0);
    check_val("rst_wrapped", 32'(bus.wrapped), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: presented before edge 1, valid after edge 3.
    bus.in_valid = 1'b1;
    bus.angle    = 9'd0;
    cur_exp      = {1'b0, 9'd0, 9'd255};
    step();
    check_val("lat_accept", 32'(last_acc), 32'd1);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_val("latency", 32'(lat), 32'd3);
    idle(3);

    // Back-to-back: one acceptance per cycle.
    t0 = $time;
    send(30,  {1'b0, 9'd127, 9'd220});
    send(90,  {1'b0, 9'd255, 9'd0});
    send(210, {1'b0, 9'(-127), 9'(-220)});
    check_val("throughput", 32'($time - t0), 32'd30);
    idle(6);

    send(450, {1'b1, 9'd255, 9'd0});
    send(359, {1'b0, 9'(-4), 9'd254});
    idle(6);
    check_val("directed_count", 32'(got_cnt), 32'd6);

    // Output held low for 5 cycles with 4 requests.
    cnt0       = got_cnt;
    stall_left = 5;
    foreach (stall_angles[i]) send(stall_angles[i], model(stall_angles[i]));
    idle(8);
    check_val("stall_count", 32'(got_cnt - cnt0), 32'd4);

    // Reset with requests in flight discards them all.
    send(10, model(10));
    send(20, model(20));
    send(40, model(40));
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle(8);
    cnt0 = got_cnt;
    send(77, model(77));
    idle(5);
    check_val("post_midrst_count", 32'(got_cnt - cnt0), 32'd1);

    // Full angle sweep with random stalls and input gaps.
    rand_mode = 1'b1;
    cnt0      = got_cnt;
    for (int ang = 0; ang < 512; ang++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(ang, model(ang));
    end
    drain();
    rand_mode = 1'b0;
    check_val("sweep_count", 32'(got_cnt - cnt0), 32'd512);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
